// File: rtl/node_argmax.sv
// Running signed argmax over one frame of node scores; result valid the cycle after the
// terminating beat, held under valid/ready backpressure (in_ready drops while a result is pending).
module node_argmax #(
   parameter int DW          = 22,
   parameter int NUM_CLASSES = 10,
   parameter int IDXW        = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DW-1:0]   in_data,
   input  logic            in_last,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [IDXW-1:0] out_class,
   output logic [DW-1:0]   out_score,
   output logic            out_err
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_CLASSES - 1);

   state_t          state, state_nxt;
   logic            armed;
   logic [DW-1:0]   max_q, max_nxt;
   logic [IDXW-1:0] idx_q, idx_nxt;
   logic [IDXW-1:0] cnt_q;
   logic            beat, term, take;

   assign beat = in_valid & in_ready;
   assign term = beat & (in_last | (cnt_q == LAST_IDX));

   // The first beat of a frame always seeds the maximum; strict > keeps the lowest index on ties.
   always_comb begin
      take    = (state == IDLE) || ($signed(in_data) > $signed(max_q));
      max_nxt = take ? in_data : max_q;
      idx_nxt = take ? cnt_q : idx_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         armed <= 1'b0;
      end else begin
         state <= state_nxt;
         armed <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (beat) state_nxt = term ? DONE : SCAN;
         SCAN:    if (term) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      out_valid = (state == DONE);
      in_ready  = armed && (state != DONE);
   end

   // cnt returns to 0 at termination so the IDLE beat always sees index 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         max_q     <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         out_class <= '0;
         out_score <= '0;
         out_err   <= 1'b0;
      end else begin
         if (beat) begin
            max_q <= max_nxt;
            idx_q <= idx_nxt;
            cnt_q <= term ? '0 : cnt_q + 1'b1;
         end
         if (term) begin
            out_class <= idx_nxt;
            out_score <= max_nxt;
            out_err   <= (cnt_q != LAST_IDX) | ~in_last;
         end
      end
   end

endmodule

// File: tb/tb_node_argmax.sv
// Directed-vector bench for node_argmax with hand-computed expected winners.
module tb_node_argmax;

   localparam int DW   = 22;
   localparam int IDXW = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [DW-1:0]   in_data;
   logic            in_last;
   logic            out_valid;
   logic            out_ready;
   logic [IDXW-1:0] out_class;
   logic [DW-1:0]   out_score;
   logic            out_err;

   int vectors    = 0;
   int miscompares = 0;
   int sc[10];

   node_argmax #(.DW(DW), .NUM_CLASSES(10), .IDXW(IDXW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_class (out_class),
      .out_score (out_score),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Entered and left on a negedge; last_at < 0 means no in_last in the frame.
   task automatic send_frame(input int n, input int last_at, input bit gaps);
      int guard;
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = DW'(sc[i]);
         in_last  = (i == last_at);
         guard = 0;
         while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
         end
         if (!in_ready) begin
            chk("beat_timeout", 32'(in_ready), 32'd1);
            break;
         end
         @(posedge clk);
         @(negedge clk);
         in_valid = 1'b0;
         in_last  = 1'b0;
         if (gaps && i != n - 1) @(negedge clk);
      end
   endtask

   task automatic finish_frame(input string tag, input int ec, input int es, input int ee);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_class"}, 32'(out_class), 32'(ec));
      chk({tag, "_score"}, 32'(out_score), 32'(es) & 32'h3F_FFFF);
      chk({tag, "_err"},   32'(out_err),   32'(ee));
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_drop"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(in_ready),  32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_class", 32'(out_class), 32'd0);
      chk("rst_score", 32'(out_score), 32'd0);
      chk("rst_err",   32'(out_err),   32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_ready", 32'(in_ready), 32'd1);

      // Ascending scores, winner is the last node.
      sc = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 100};
      send_frame(10, 9, 1'b0);
      finish_frame("t1", 9, 100, 0);
      chk("t1_keep_class", 32'(out_class), 32'd9);
      chk("t1_keep_score", 32'(out_score), 32'd100);

      // Tie at nodes 3 and 7, delivered with gaps.
      sc = '{1, 2, 3, 500, 4, 5, 6, 500, 7, 8};
      send_frame(10, 9, 1'b1);
      finish_frame("t2", 3, 500, 0);

      sc = '{-5, -3, -9, -3, -100, -7, -8, -6, -4, -2000000};
      send_frame(10, 9, 1'b0);
      finish_frame("t3a", 1, -3, 0);

      sc = '{-2097152, -2097152, -2097152, -2097152, -2097152,
             -2097152, -2097152, -2097152, -2097152, -2097152};
      send_frame(10, 9, 1'b0);
      finish_frame("t3b", 0, -2097152, 0);

      // Short frame and frame missing in_last.
      sc = '{1, 2, 50, 3, 0, 0, 0, 0, 0, 0};
      send_frame(4, 3, 1'b0);
      finish_frame("t4a", 2, 50, 1);

      sc = '{7, 3, 9, 1, 2, 40, 5, 6, 8, 4};
      send_frame(10, -1, 1'b0);
      finish_frame("t4b", 5, 40, 1);

      // Backpressure: result held, a stray beat offered meanwhile is ignored.
      sc = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
      send_frame(10, 9, 1'b0);
      in_valid = 1'b1;
      in_data  = DW'(999);
      in_last  = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("t5_hold_valid", 32'(out_valid), 32'd1);
         chk("t5_hold_ready", 32'(in_ready),  32'd0);
         chk("t5_hold_class", 32'(out_class), 32'd5);
         chk("t5_hold_score", 32'(out_score), 32'd9);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      finish_frame("t5", 5, 9, 0);
      chk("t5_ready_again", 32'(in_ready), 32'd1);
      sc = '{0, 0, 0, 0, 0, 0, 0, 0, 11, 0};
      send_frame(10, 9, 1'b0);
      finish_frame("t5n", 8, 11, 0);

      // Reset in the middle of a frame whose partial maximum is large.
      sc = '{900, 800, 700, 600, 500, 0, 0, 0, 0, 0};
      send_frame(5, -1, 1'b0);
      rst = 1'b0;
      #1;
      chk("t6_rst_ready", 32'(in_ready),  32'd0);
      chk("t6_rst_valid", 32'(out_valid), 32'd0);
      chk("t6_rst_score", 32'(out_score), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      sc = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
      send_frame(10, 9, 1'b0);
      finish_frame("t6", 9, 10, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
